block_write_back: RTL and testbench

Post-IDCT write-back engine. Reads one 8x8 block of signed 32-bit results from the result dual-port RAM that the matrix multiplier fills with the S pass. Scales and clips each value to an 8-bit pixel, packs horizontal pixel pairs into 16-bit words, and writes the 32 words of the block into external SRAM at the block's position in the 320x240 image. It consumes the multiplier's write port contents and runs after MM_done for the S pass.

---
 rtl/block_write_back_pkg.sv | 38 +++
 rtl/block_write_back_if.sv | 26 ++
 rtl/block_write_back_pixel_clip.sv | 30 +++
 rtl/block_write_back.sv | 177 +++++++++++++++++
 tb/tb_block_write_back.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/block_write_back_pkg.sv
// Shared state/constant header for the IDCT back-end stages.
// Holds the write-back FSM state enum, image geometry and scaling constants,
// and a constant-multiply helper that expands into shift-add terms so
// address generation never infers a hardware multiplier.
package block_write_back_pkg;

  // SRAM words per image row (320 pixels, two pixels per word)
  localparam int IMAGE_WIDTH_WORDS = 160;
  // Arithmetic right shift applied to IDCT results before clipping
  localparam int SCALE_SHIFT = 16;

  typedef enum logic [2:0] {
    S_WB_IDLE = 3'd0,
    S_WB_READ = 3'd1,
    S_WB_LO_0 = 3'd2,
    S_WB_LO_1 = 3'd3,
    S_WB_DONE = 3'd4
  } WB_state_type;

  // a * m modulo 2^18, built as a sum of shifted copies of a (one per set
  // bit of the constant m; 160 = 128 + 32 gives two terms).
  function automatic logic [17:0] mul_const_18(input logic [7:0] a,
                                               input logic [17:0] m);
    logic [17:0] acc_s;
    logic [17:0] ext_s;
    acc_s = 18'd0;
    ext_s = {10'd0, a};
    for (int i = 0; i < 18; i++) begin
      if (m[i]) begin
        acc_s = acc_s + (ext_s << i);
      end else begin
        acc_s = acc_s;
      end
    end
    return acc_s;
  endfunction

endpackage

// File: rtl/block_write_back_if.sv
// Bus bundle for the write-back engine.
// Groups the start/done handshake, block position, result-RAM read port and
// external SRAM write port.
//   master : the write-back engine (drives WB_done, S_read_address, SRAM_*)
//   slave  : the surrounding system (drives WB_start, block_row/col, S_read_data)
interface block_write_back_if;
  logic        WB_start;
  logic        WB_done;
  logic [4:0]  block_row;
  logic [5:0]  block_col;
  logic [6:0]  S_read_address;
  logic [31:0] S_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    input  WB_start, block_row, block_col, S_read_data,
    output WB_done, S_read_address, SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport slave (
    output WB_start, block_row, block_col, S_read_data,
    input  WB_done, S_read_address, SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/block_write_back_pixel_clip.sv
// pixel_clip: combinational conversion of a signed 32-bit IDCT result to an
// 8-bit pixel. The value is arithmetically shifted right by SHIFT, then
// saturated to 0..255 (negative -> 0, above 255 -> 255).
// Ports:
//   value  in  32  signed input sample
//   pixel  out 8   clipped pixel
module pixel_clip
  import block_write_back_pkg::*;
#(
  parameter int SHIFT = block_write_back_pkg::SCALE_SHIFT
) (
  input  logic signed [31:0] value,
  output logic        [7:0]  pixel
);

  logic signed [31:0] shifted_s;

  // Scale then saturate to the 8-bit pixel range
  always_comb begin
    shifted_s = value >>> SHIFT;
    if (shifted_s < 32'sd0) begin
      pixel = 8'd0;
    end else if (shifted_s > 32'sd255) begin
      pixel = 8'd255;
    end else begin
      pixel = shifted_s[7:0];
    end
  end

endmodule

// File: rtl/block_write_back.sv
// block_write_back: post-IDCT write-back engine.
// Reads the 64 results of one 8x8 block from the result RAM in raster order,
// clips each to a pixel, pairs horizontally adjacent pixels into 16-bit words
// and writes the 32 words to SRAM at the block's place in the 320x240 image.
// Ports:
//   CLOCK_50_I  in   system clock
//   Resetn      in   asynchronous active-low reset (aborts any block)
//   bus         master side of block_write_back_if:
//     WB_start/WB_done handshake, block_row/block_col position (latched at
//     start), S_read_address/S_read_data result-RAM port (1-cycle latency),
//     SRAM_address/SRAM_write_data/SRAM_we_n registered SRAM write port.
// Start-to-done latency is 67 cycles regardless of data.
module block_write_back
  import block_write_back_pkg::*;
#(
  parameter int          IMAGE_WIDTH_WORDS = block_write_back_pkg::IMAGE_WIDTH_WORDS,
  parameter logic [17:0] DST_BASE          = 18'd0,
  parameter logic [6:0]  S_BASE            = 7'd0,
  parameter int          SCALE_SHIFT       = block_write_back_pkg::SCALE_SHIFT
) (
  input  logic                CLOCK_50_I,
  input  logic                Resetn,
  block_write_back_if.master  bus
);

  WB_state_type state_r, state_s;

  // Read-issue side: index of the element whose address is on the bus
  logic [5:0]  issue_k_r, issue_k_s;
  logic        issue_valid_r, issue_valid_s;
  logic [6:0]  rd_addr_r, rd_addr_s;

  // Data side: the element whose result is on S_read_data this cycle
  logic [5:0]  data_k_r;
  logic        data_valid_r;

  logic        latch_s;
  logic        done_r, done_s;
  logic [4:0]  row_r;
  logic [5:0]  col_r;
  logic [7:0]  pair_hi_r;

  logic [17:0] sram_addr_r;
  logic [15:0] sram_data_r;
  logic        we_n_r;

  logic [7:0]  pixel_s;
  logic [7:0]  row_term_s;
  logic [7:0]  col_term_s;
  logic [17:0] wr_addr_s;

  pixel_clip #(
    .SHIFT (SCALE_SHIFT)
  ) u_pixel_clip (
    .value (bus.S_read_data),
    .pixel (pixel_s)
  );

  // Next-state and next read address / done pulse
  always_comb begin
    state_s       = state_r;
    issue_k_s     = issue_k_r;
    issue_valid_s = 1'b0;
    rd_addr_s     = rd_addr_r;
    done_s        = 1'b0;
    latch_s       = 1'b0;
    case (state_r)
      S_WB_IDLE: begin
        if (bus.WB_start) begin
          state_s       = S_WB_READ;
          issue_k_s     = 6'd0;
          issue_valid_s = 1'b1;
          rd_addr_s     = S_BASE;
          latch_s       = 1'b1;
        end else begin
          state_s = S_WB_IDLE;
        end
      end
      S_WB_READ: begin
        if (issue_k_r == 6'd63) begin
          state_s = S_WB_LO_0;
        end else begin
          issue_k_s     = issue_k_r + 6'd1;
          issue_valid_s = 1'b1;
          rd_addr_s     = S_BASE + {1'b0, issue_k_s};
        end
      end
      // Element 63's data arrives here; its pair is written next cycle
      S_WB_LO_0: begin
        state_s = S_WB_LO_1;
      end
      S_WB_LO_1: begin
        state_s = S_WB_DONE;
        done_s  = 1'b1;
      end
      S_WB_DONE: begin
        state_s = S_WB_IDLE;
      end
      default: begin
        state_s = S_WB_IDLE;
      end
    endcase
  end

  // FSM state, read-issue counter and done pulse registers
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state_r       <= S_WB_IDLE;
      issue_k_r     <= 6'd0;
      issue_valid_r <= 1'b0;
      rd_addr_r     <= 7'd0;
      done_r        <= 1'b0;
      data_k_r      <= 6'd0;
      data_valid_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      issue_k_r     <= issue_k_s;
      issue_valid_r <= issue_valid_s;
      rd_addr_r     <= rd_addr_s;
      done_r        <= done_s;
      data_k_r      <= issue_k_r;
      data_valid_r  <= issue_valid_r;
    end
  end

  // Block position is captured once so the caller may change it mid-block
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      row_r <= 5'd0;
      col_r <= 6'd0;
    end else if (latch_s) begin
      row_r <= bus.block_row;
      col_r <= bus.block_col;
    end else begin
      row_r <= row_r;
      col_r <= col_r;
    end
  end

  // Image row = 8*block_row + r, word column = 4*block_col + c/2, both of
  // which are plain bit concatenations of the latched position and k.
  always_comb begin
    row_term_s = {row_r, data_k_r[5:3]};
    col_term_s = {col_r, data_k_r[2:1]};
    wr_addr_s  = DST_BASE
               + mul_const_18(row_term_s, 18'(IMAGE_WIDTH_WORDS))
               + {10'd0, col_term_s};
  end

  // Pixel pairing and registered SRAM write port
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      pair_hi_r   <= 8'd0;
      sram_addr_r <= 18'd0;
      sram_data_r <= 16'd0;
      we_n_r      <= 1'b1;
    end else if (data_valid_r) begin
      if (!data_k_r[0]) begin
        pair_hi_r <= pixel_s;
        we_n_r    <= 1'b1;
      end else begin
        sram_addr_r <= wr_addr_s;
        sram_data_r <= {pair_hi_r, pixel_s};
        we_n_r      <= 1'b0;
      end
    end else begin
      we_n_r <= 1'b1;
    end
  end

  assign bus.S_read_address  = rd_addr_r;
  assign bus.WB_done         = done_r;
  assign bus.SRAM_address    = sram_addr_r;
  assign bus.SRAM_write_data = sram_data_r;
  assign bus.SRAM_we_n       = we_n_r;

endmodule

// File: tb/tb_block_write_back.sv
// Self-checking bench for block_write_back: a result-RAM model feeds the DUT,
// and each block's 32 SRAM writes are compared cycle by cycle against a
// reference computed directly from the image-geometry and clipping rules.
module tb_block_write_back;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  block_write_back_if bus();

  block_write_back dut (
    .CLOCK_50_I (clk),
    .Resetn     (rstn),
    .bus        (bus)
  );

  logic [31:0] ram [0:127];

  // Result RAM with one-cycle read latency
  always @(posedge clk) bus.S_read_data <= ram[bus.S_read_address];

  int vectors = 0;
  int miscompares = 0;
  int obs_addr [32];
  int obs_data [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clip(input logic [31:0] v);
    int s;
    s = v;
    s = s >>> 16;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 128; i++) begin
      case ($urandom_range(0, 3))
        0: ram[i] = $urandom;
        1: ram[i] = ($urandom_range(0, 300) << 16) | ($urandom & 32'h0000_FFFF);
        2: ram[i] = -$urandom_range(0, 100000);
        3: ram[i] = $urandom_range(0, 255) << 16;
        default: ram[i] = 32'd0;
      endcase
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".we_n"}, bus.SRAM_we_n, 1'b1);
    check({tag, ".done"}, bus.WB_done, 1'b0);
    check({tag, ".addr"}, bus.SRAM_address, 18'd0);
    check({tag, ".data"}, bus.SRAM_write_data, 16'd0);
    check({tag, ".rdaddr"}, bus.S_read_address, 7'd0);
  endtask

  // Runs one block from start to a few cycles past done; optional extra
  // start requests at cycle 30 and during DONE must be ignored.
  task automatic run_block(input int br, input int bc, input bit extra_starts);
    int exp_addr [32];
    int exp_data [32];
    int writes;
    int dones;
    bit exp_we;
    int w;
    writes = 0;
    dones = 0;
    for (int i = 0; i < 32; i++) begin
      int r, j;
      r = i / 4;
      j = i % 4;
      exp_addr[i] = ((8 * br + r) * 160 + 4 * bc + j) % 262144;
      exp_data[i] = clip(ram[8 * r + 2 * j]) * 256 + clip(ram[8 * r + 2 * j + 1]);
    end
    @(negedge clk);
    bus.block_row = br[4:0];
    bus.block_col = bc[5:0];
    bus.WB_start  = 1'b1;
    for (int t = 1; t <= 72; t++) begin
      @(negedge clk);
      if (t == 1) begin
        // Position is latched; scramble the inputs to prove it
        bus.block_row = 5'($urandom);
        bus.block_col = 6'($urandom);
      end
      exp_we = (t >= 4) && (t <= 66) && (t % 2 == 0);
      check($sformatf("we_n@%0d", t), bus.SRAM_we_n, !exp_we);
      if (exp_we) begin
        w = (t - 4) / 2;
        obs_addr[w] = bus.SRAM_address;
        obs_data[w] = bus.SRAM_write_data;
        check($sformatf("addr[%0d]", w), bus.SRAM_address, exp_addr[w]);
        check($sformatf("data[%0d]", w), bus.SRAM_write_data, exp_data[w]);
      end
      check($sformatf("done@%0d", t), bus.WB_done, t == 67);
      if (t <= 64) check($sformatf("rdaddr@%0d", t), bus.S_read_address, t - 1);
      if (!bus.SRAM_we_n) writes++;
      if (bus.WB_done) dones++;
      bus.WB_start = extra_starts && (t == 30 || t == 67);
    end
    check("write_count", writes, 32);
    check("done_count", dones, 1);
  endtask

  initial begin
    int br, bc;
    int abort_writes;
    bus.WB_start  = 1'b0;
    bus.block_row = 5'd0;
    bus.block_col = 6'd0;
    for (int i = 0; i < 128; i++) ram[i] = 32'd0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Reset, no start: outputs hold reset values
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check_idle($sformatf("rst_idle%0d", t));
    end

    // Block (0,0), all-zero results
    run_block(0, 0, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("zero_addr%0d", i * 4 + 3), obs_addr[i * 4 + 3], i * 160 + 3);

    // Clip / pack corner values
    ram[0] = 32'hFFFF_0000;
    ram[1] = 32'h0080_8000;
    ram[2] = 32'h0100_0000;
    ram[3] = 32'h00FF_0000;
    run_block(0, 0, 1'b0);
    check("clip_word0", obs_data[0], 16'h0080);
    check("clip_word1", obs_data[1], 16'hFFFF);

    // Bottom-right block with ignored extra starts
    fill_random();
    run_block(29, 39, 1'b1);
    check("br_first_addr", obs_addr[0], 37276);
    check("br_last_addr", obs_addr[31], 38399);

    // Reset in the middle of a block
    fill_random();
    @(negedge clk);
    bus.block_row = 5'd7;
    bus.block_col = 6'd11;
    bus.WB_start  = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      bus.WB_start = 1'b0;
    end
    check("pre_abort_we_n", bus.SRAM_we_n, 1'b0);
    rstn = 1'b0;
    #1;
    check_idle("abort");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    abort_writes = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (!bus.SRAM_we_n) abort_writes++;
      check($sformatf("post_abort_done%0d", t), bus.WB_done, 1'b0);
    end
    check("post_abort_writes", abort_writes, 0);
    run_block(7, 11, 1'b0);

    // Random blocks, positions and data
    for (int n = 0; n < 4; n++) begin
      fill_random();
      br = $urandom_range(0, 29);
      bc = $urandom_range(0, 39);
      run_block(br, bc, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
